// File: rtl/sensor_seq_pkg.sv
// Shared types and sizing helpers for the sensor power sequencer.
// Channel states, retry counter width and counter-width computation.
package sensor_seq_pkg;

   typedef enum logic [2:0] {
      HOLD,
      BOOT,
      INIT,
      RUN,
      RETRY,
      FAULT
   } seq_state_e;

   localparam int RETRY_W = 4;

   function automatic int unsigned umax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Wide enough to hold every count value up to max_dur.
   function automatic int cnt_width(input int unsigned max_dur);
      return (max_dur < 2) ? 1 : $clog2(max_dur + 1);
   endfunction

endpackage

// File: rtl/sensor_seq_channel.sv
// One BNO085 power/recovery sequencing channel: FSM plus phase counter.
// CHAN_IDX scales the extra NRST hold applied on the first pass after reset/fault_clr.
//
// state | meaning
// HOLD  | sensor NRST and controller reset asserted
// BOOT  | NRST released, waiting for sensor boot
// INIT  | controller released, waiting for sensor_initialized
// RUN   | channel ready, watchdog on data_valid
// RETRY | single cycle, decide between another pass and FAULT
// FAULT | latched failure, waiting for fault_clr
module sensor_seq_channel
   import sensor_seq_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYC = 300_000,
   parameter int unsigned BOOT_CYC     = 5_700_000,
   parameter int unsigned STAGGER_CYC  = 30_000,
   parameter int unsigned INIT_TO_CYC  = 3_000_000,
   parameter int unsigned WDOG_CYC     = 300_000,
   parameter int unsigned MAX_RETRIES  = 3,
   parameter int unsigned CHAN_IDX     = 0
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               initialized_i,
   input  logic               error_i,
   input  logic               data_valid_i,
   input  logic               fault_clr_i,
   output logic               sensor_rst_n_o,
   output logic               ctrl_rst_n_o,
   output logic               ready_o,
   output logic               fault_o,
   output logic [RETRY_W-1:0] retry_cnt_o
);

   localparam int unsigned HOLD_FIRST = RST_HOLD_CYC + CHAN_IDX * STAGGER_CYC;
   localparam int unsigned MAX_DUR    = umax(umax(HOLD_FIRST, BOOT_CYC),
                                             umax(INIT_TO_CYC, WDOG_CYC));
   localparam int CW = cnt_width(MAX_DUR);

   // Terminal counts: a phase of duration D ends when the counter shows D-1.
   localparam logic [CW-1:0] HOLD_LAST       = CW'(RST_HOLD_CYC - 1);
   localparam logic [CW-1:0] HOLD_FIRST_LAST = CW'(HOLD_FIRST - 1);
   localparam logic [CW-1:0] BOOT_LAST       = CW'(BOOT_CYC - 1);
   localparam logic [CW-1:0] INIT_LAST       = CW'(INIT_TO_CYC - 1);
   localparam logic [CW-1:0] WDOG_LAST       = CW'((WDOG_CYC == 0) ? 0 : WDOG_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

   seq_state_e         state_q;
   logic [CW-1:0]      cnt_q;
   logic [RETRY_W-1:0] retry_q;
   logic               first_q;
   logic               sensor_rst_n_q;
   logic               ctrl_rst_n_q;
   logic               ready_q;
   logic               fault_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q        <= HOLD;
         cnt_q          <= '0;
         retry_q        <= '0;
         first_q        <= 1'b1;
         sensor_rst_n_q <= 1'b0;
         ctrl_rst_n_q   <= 1'b0;
         ready_q        <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         case (state_q)
            HOLD: begin
               if (cnt_q == (first_q ? HOLD_FIRST_LAST : HOLD_LAST)) begin
                  state_q        <= BOOT;
                  cnt_q          <= '0;
                  sensor_rst_n_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            BOOT: begin
               if (cnt_q == BOOT_LAST) begin
                  state_q      <= INIT;
                  cnt_q        <= '0;
                  ctrl_rst_n_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            INIT: begin
               if (error_i || (!initialized_i && cnt_q == INIT_LAST)) begin
                  state_q        <= RETRY;
                  cnt_q          <= '0;
                  sensor_rst_n_q <= 1'b0;
                  ctrl_rst_n_q   <= 1'b0;
               end else if (initialized_i) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (error_i || !initialized_i ||
                   (WDOG_CYC != 0 && !data_valid_i && cnt_q == WDOG_LAST)) begin
                  state_q        <= RETRY;
                  cnt_q          <= '0;
                  sensor_rst_n_q <= 1'b0;
                  ctrl_rst_n_q   <= 1'b0;
                  ready_q        <= 1'b0;
               end else if (data_valid_i) begin
                  cnt_q <= '0;
               end else if (WDOG_CYC != 0) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RETRY: begin
               cnt_q <= '0;
               if (retry_q < RETRY_MAX) begin
                  state_q <= HOLD;
                  retry_q <= retry_q + 1'b1;
                  first_q <= 1'b0;
               end else begin
                  state_q <= FAULT;
                  fault_q <= 1'b1;
               end
            end
            FAULT: begin
               if (fault_clr_i) begin
                  state_q <= HOLD;
                  cnt_q   <= '0;
                  retry_q <= '0;
                  first_q <= 1'b1;
                  fault_q <= 1'b0;
               end
            end
            default: begin
               state_q        <= HOLD;
               cnt_q          <= '0;
               sensor_rst_n_q <= 1'b0;
               ctrl_rst_n_q   <= 1'b0;
               ready_q        <= 1'b0;
               fault_q        <= 1'b0;
            end
         endcase
      end
   end

   assign sensor_rst_n_o = sensor_rst_n_q;
   assign ctrl_rst_n_o   = ctrl_rst_n_q;
   assign ready_o        = ready_q;
   assign fault_o        = fault_q;
   assign retry_cnt_o    = retry_q;

endmodule

// File: rtl/sensor_power_sequencer.sv
// N-channel BNO085 power-up/recovery sequencer: one independent channel per sensor,
// plus a free-running heartbeat and the all_ready/any_fault summaries.
module sensor_power_sequencer
   import sensor_seq_pkg::*;
#(
   parameter int unsigned N_SENSORS    = 2,
   parameter int unsigned RST_HOLD_CYC = 300_000,
   parameter int unsigned BOOT_CYC     = 5_700_000,
   parameter int unsigned STAGGER_CYC  = 30_000,
   parameter int unsigned INIT_TO_CYC  = 3_000_000,
   parameter int unsigned WDOG_CYC     = 300_000,
   parameter int unsigned MAX_RETRIES  = 3,
   parameter int unsigned HB_BIT       = 21
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic [N_SENSORS-1:0]           sensor_initialized_i,
   input  logic [N_SENSORS-1:0]           sensor_error_i,
   input  logic [N_SENSORS-1:0]           data_valid_i,
   input  logic [N_SENSORS-1:0]           fault_clr_i,
   output logic [N_SENSORS-1:0]           sensor_rst_n_o,
   output logic [N_SENSORS-1:0]           ctrl_rst_n_o,
   output logic [N_SENSORS-1:0]           ready_o,
   output logic [N_SENSORS-1:0]           fault_o,
   output logic [RETRY_W*N_SENSORS-1:0]   retry_cnt_o,
   output logic                           all_ready_o,
   output logic                           any_fault_o,
   output logic                           heartbeat_o
);

   logic [HB_BIT:0] hb_q;

   for (genvar g = 0; g < N_SENSORS; g++) begin : g_chan
      sensor_seq_channel #(
         .RST_HOLD_CYC (RST_HOLD_CYC),
         .BOOT_CYC     (BOOT_CYC),
         .STAGGER_CYC  (STAGGER_CYC),
         .INIT_TO_CYC  (INIT_TO_CYC),
         .WDOG_CYC     (WDOG_CYC),
         .MAX_RETRIES  (MAX_RETRIES),
         .CHAN_IDX     (g)
      ) u_chan (
         .clk_i          (clk_i),
         .rst_n_i        (rst_n_i),
         .initialized_i  (sensor_initialized_i[g]),
         .error_i        (sensor_error_i[g]),
         .data_valid_i   (data_valid_i[g]),
         .fault_clr_i    (fault_clr_i[g]),
         .sensor_rst_n_o (sensor_rst_n_o[g]),
         .ctrl_rst_n_o   (ctrl_rst_n_o[g]),
         .ready_o        (ready_o[g]),
         .fault_o        (fault_o[g]),
         .retry_cnt_o    (retry_cnt_o[RETRY_W*g +: RETRY_W])
      );
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         hb_q <= '0;
      end else begin
         hb_q <= hb_q + 1'b1;
      end
   end

   // Reductions of registered flags, so they move on the same edge as the channels.
   assign all_ready_o = &ready_o;
   assign any_fault_o = |fault_o;
   assign heartbeat_o = hb_q[HB_BIT];

endmodule

// File: tb/tb_sensor_power_sequencer.sv
// Self-checking bench for sensor_power_sequencer: directed scenarios plus random
// stimulus, compared against a timestamp-based behavioural model.
module tb_sensor_power_sequencer;

   localparam int N       = 2;
   localparam int RHOLD   = 4;
   localparam int BOOTC   = 6;
   localparam int STAG    = 3;
   localparam int INITTO  = 10;
   localparam int WDOG    = 8;
   localparam int MAXR    = 2;
   localparam int HBB     = 3;

   localparam int P_HOLD = 0, P_BOOT = 1, P_INIT = 2, P_RUN = 3, P_RETRY = 4, P_FAULT = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   ini, err, dv, fclr;
   logic [N-1:0]   sensor_rst_n, ctrl_rst_n, ready, fault;
   logic [4*N-1:0] retry_cnt;
   logic           all_ready, any_fault, heartbeat;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: phase per channel, cycle of entry, last watchdog reload, retries, first-pass flag.
   int cyc = 0;
   int hb  = 0;
   int ph[N], t_in[N], ref_dv[N], retries[N];
   bit first[N];

   sensor_power_sequencer #(
      .N_SENSORS(N), .RST_HOLD_CYC(RHOLD), .BOOT_CYC(BOOTC), .STAGGER_CYC(STAG),
      .INIT_TO_CYC(INITTO), .WDOG_CYC(WDOG), .MAX_RETRIES(MAXR), .HB_BIT(HBB)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .sensor_initialized_i(ini), .sensor_error_i(err),
      .data_valid_i(dv), .fault_clr_i(fclr),
      .sensor_rst_n_o(sensor_rst_n), .ctrl_rst_n_o(ctrl_rst_n),
      .ready_o(ready), .fault_o(fault), .retry_cnt_o(retry_cnt),
      .all_ready_o(all_ready), .any_fault_o(any_fault), .heartbeat_o(heartbeat)
   );

   always #5 clk = ~clk;

   task automatic enter(input int c, input int p);
      ph[c]   = p;
      t_in[c] = cyc;
   endtask

   task automatic model_step();
      cyc++;
      if (!rst_n) begin
         hb = 0;
         for (int c = 0; c < N; c++) begin
            enter(c, P_HOLD);
            first[c]   = 1'b1;
            retries[c] = 0;
         end
      end else begin
         hb++;
         for (int c = 0; c < N; c++) begin
            int e;
            e = cyc - t_in[c];
            case (ph[c])
               P_HOLD:  if (e == RHOLD + (first[c] ? c * STAG : 0)) enter(c, P_BOOT);
               P_BOOT:  if (e == BOOTC) enter(c, P_INIT);
               P_INIT: begin
                  if (err[c]) enter(c, P_RETRY);
                  else if (ini[c]) begin enter(c, P_RUN); ref_dv[c] = cyc; end
                  else if (e == INITTO) enter(c, P_RETRY);
               end
               P_RUN: begin
                  if (err[c] || !ini[c]) enter(c, P_RETRY);
                  else if (dv[c]) ref_dv[c] = cyc;
                  else if (WDOG != 0 && cyc - ref_dv[c] == WDOG) enter(c, P_RETRY);
               end
               P_RETRY: begin
                  if (retries[c] < MAXR) begin
                     retries[c]++;
                     first[c] = 1'b0;
                     enter(c, P_HOLD);
                  end else begin
                     enter(c, P_FAULT);
                  end
               end
               default: if (fclr[c]) begin
                  retries[c] = 0;
                  first[c]   = 1'b1;
                  enter(c, P_HOLD);
               end
            endcase
         end
      end
   endtask

   function automatic logic [18:0] exp_vec();
      logic [N-1:0]   s, k, r, f;
      logic [4*N-1:0] rc;
      logic           hbit;
      for (int c = 0; c < N; c++) begin
         s[c] = (ph[c] == P_BOOT) || (ph[c] == P_INIT) || (ph[c] == P_RUN);
         k[c] = (ph[c] == P_INIT) || (ph[c] == P_RUN);
         r[c] = (ph[c] == P_RUN);
         f[c] = (ph[c] == P_FAULT);
         rc[4*c +: 4] = 4'(retries[c]);
      end
      hbit = 1'((hb >> HBB) & 1);
      return {s, k, r, f, rc, &r, |f, hbit};
   endfunction

   function automatic logic [18:0] act_vec();
      return {sensor_rst_n, ctrl_rst_n, ready, fault, retry_cnt, all_ready, any_fault, heartbeat};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ini = '0; err = '0; dv = '0; fclr = '0;
      repeat (3) begin
         tick();
         n_tests++;
         if (act_vec() !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_values got %h want %h", act_vec(), 19'h0);
         end
      end
   endtask

   task automatic test_power_up();
      int rs0 = -1, cr0 = -1, rd0 = -1, rs1 = -1, cr1 = -1, rd1 = -1, ar = -1;
      rst_n = 1'b1; ini = 2'b11; dv = 2'b11;
      for (int k = 1; k <= 20; k++) begin
         tick();
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL power_up edge %0d got %h want %h", k, act_vec(), exp_vec());
         end
         if (rs0 < 0 && sensor_rst_n[0]) rs0 = k;
         if (cr0 < 0 && ctrl_rst_n[0])   cr0 = k;
         if (rd0 < 0 && ready[0])        rd0 = k;
         if (rs1 < 0 && sensor_rst_n[1]) rs1 = k;
         if (cr1 < 0 && ctrl_rst_n[1])   cr1 = k;
         if (rd1 < 0 && ready[1])        rd1 = k;
         if (ar < 0 && all_ready)        ar = k;
      end
      n_tests++;
      if ({rs0, cr0, rd0} !== {32'd4, 32'd10, 32'd11}) begin
         n_fail++;
         $display("FAIL pu_ch0_edges got %0d/%0d/%0d want 4/10/11", rs0, cr0, rd0);
      end
      n_tests++;
      if ({rs1, cr1, rd1, ar} !== {32'd7, 32'd13, 32'd14, 32'd14}) begin
         n_fail++;
         $display("FAIL pu_ch1_edges got %0d/%0d/%0d all_ready %0d want 7/13/14 14", rs1, cr1, rd1, ar);
      end
   endtask

   task automatic test_watchdog();
      int n;
      for (int k = 0; k < 30; k++) begin
         dv[0] = (k % 5 == 0);
         tick();
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL wdog_feed got %h want %h", act_vec(), exp_vec());
         end
      end
      n_tests++;
      if (ready !== 2'b11) begin
         n_fail++;
         $display("FAIL wdog_keep_ready got %b want 11", ready);
      end
      dv[0] = 1'b1;
      tick();
      dv[0] = 1'b0;
      n = 0;
      while (ready[0] && n < 20) begin
         tick();
         n++;
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL wdog_starve got %h want %h", act_vec(), exp_vec());
         end
      end
      n_tests++;
      if (n != WDOG) begin
         n_fail++;
         $display("FAIL wdog_expiry got %0d cycles want %0d", n, WDOG);
      end
      dv[0] = 1'b1;
      tick();
      n_tests++;
      if (retry_cnt[3:0] !== 4'd1 || sensor_rst_n[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL wdog_retry_cnt got %0d nrst %b want 1 0", retry_cnt[3:0], sensor_rst_n[0]);
      end
      n = 0;
      while (!sensor_rst_n[0] && n < 20) begin
         tick();
         n++;
      end
      n_tests++;
      if (n != RHOLD) begin
         n_fail++;
         $display("FAIL wdog_hold_len got %0d want %0d", n, RHOLD);
      end
      n = 0;
      while (!ready[0] && n < 40) begin
         tick();
         n++;
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL wdog_rerun got %h want %h", act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_fault();
      int n = 0, run = 0, last_run = 0;
      ini[0] = 1'b0;
      while (!fault[0] && n < 200) begin
         tick();
         n++;
         if (ctrl_rst_n[0]) run++;
         else begin
            if (run != 0) last_run = run;
            run = 0;
         end
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fault_seq got %h want %h", act_vec(), exp_vec());
         end
      end
      n_tests++;
      if ({fault[0], any_fault, retry_cnt[3:0], ready[1], all_ready} !== {1'b1, 1'b1, 4'd2, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL fault_latch got f%b af%b rc%0d r1%b ar%b want f1 af1 rc2 r1=1 ar0",
                  fault[0], any_fault, retry_cnt[3:0], ready[1], all_ready);
      end
      n_tests++;
      if (last_run != INITTO) begin
         n_fail++;
         $display("FAIL init_timeout_len got %0d want %0d", last_run, INITTO);
      end
      repeat (5) begin
         tick();
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fault_hold got %h want %h", act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_fault_clr();
      int n = 0;
      ini[0] = 1'b1; dv[0] = 1'b1; fclr[0] = 1'b1;
      tick();
      fclr[0] = 1'b0;
      n_tests++;
      if ({fault[0], retry_cnt[3:0], sensor_rst_n[0]} !== {1'b0, 4'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL fclr_exit got f%b rc%0d nrst%b want f0 rc0 nrst0", fault[0], retry_cnt[3:0], sensor_rst_n[0]);
      end
      while (!ready[0] && n < 40) begin
         tick();
         n++;
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL fclr_resequence got %h want %h", act_vec(), exp_vec());
         end
      end
      n_tests++;
      if (n != RHOLD + BOOTC + 1) begin
         n_fail++;
         $display("FAIL fclr_seq_len got %0d want %0d", n, RHOLD + BOOTC + 1);
      end
      fclr = 2'b11;
      tick();
      fclr = 2'b00;
      tick();
      n_tests++;
      if ({ready, retry_cnt, fault} !== {2'b11, 8'h00, 2'b00}) begin
         n_fail++;
         $display("FAIL fclr_in_run got r%b rc%h f%b want r11 rc00 f00", ready, retry_cnt, fault);
      end
   endtask

   task automatic test_error_priority();
      int n = 0;
      err[0] = 1'b1; dv[0] = 1'b1;
      tick();
      err[0] = 1'b0;
      n_tests++;
      if ({ready[0], sensor_rst_n[0], ctrl_rst_n[0]} !== 3'b000) begin
         n_fail++;
         $display("FAIL err_beats_dv got %b want 000", {ready[0], sensor_rst_n[0], ctrl_rst_n[0]});
      end
      ini[0] = 1'b0;
      while (!ctrl_rst_n[0] && n < 40) begin
         tick();
         n++;
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL err_to_init got %h want %h", act_vec(), exp_vec());
         end
      end
      err[0] = 1'b1;
      tick();
      err[0] = 1'b0;
      n_tests++;
      if ({ctrl_rst_n[0], sensor_rst_n[0]} !== 2'b00 || act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL err_in_init got %h want %h", act_vec(), exp_vec());
      end
      ini[0] = 1'b1;
   endtask

   task automatic test_reset_mid();
      int n = 0, rs1 = -1;
      ini = 2'b11; dv = 2'b11; err = '0; fclr = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      while (!sensor_rst_n[0] && n < 20) begin tick(); n++; end
      tick();
      rst_n = 1'b0;
      tick();
      n_tests++;
      if (act_vec() !== 19'h0) begin
         n_fail++;
         $display("FAIL reset_mid_boot got %h want 0", act_vec());
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (rs1 < 0 && sensor_rst_n[1]) rs1 = k;
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL restart_seq edge %0d got %h want %h", k, act_vec(), exp_vec());
         end
      end
      n_tests++;
      if (rs1 != RHOLD + STAG || all_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_stagger got edge %0d all_ready %b want %0d 1", rs1, all_ready, RHOLD + STAG);
      end
      rst_n = 1'b0;
      tick();
      n_tests++;
      if (act_vec() !== 19'h0) begin
         n_fail++;
         $display("FAIL reset_mid_run got %h want 0", act_vec());
      end
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         for (int c = 0; c < N; c++) begin
            ini[c]  = ($urandom_range(0, 19) != 0);
            err[c]  = ($urandom_range(0, 59) == 0);
            dv[c]   = ($urandom_range(0, 3) == 0);
            fclr[c] = ($urandom_range(0, 9) == 0);
         end
         tick();
         n_tests++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cycle %0d got %h want %h", k, act_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_watchdog();
      test_fault();
      test_fault_clr();
      test_error_priority();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
